// File: rtl/line_loader_pkg.sv
// Shared constants and state encoding for the serial-to-line loader.
`default_nettype none

package line_loader_pkg;

  localparam int PLANE_DIM = 5;
  localparam int LINE_W    = PLANE_DIM * PLANE_DIM;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  // Flat line index of plane cell (i, j).
  function automatic int plane_index(input int i, input int j);
    return PLANE_DIM * i + j;
  endfunction

endpackage

`default_nettype wire

// File: rtl/line_loader_bit_collector.sv
// Assembly register and bit counter: writes serial bits into ascending line positions.
`default_nettype none

module line_loader_bit_collector
  import line_loader_pkg::*;
#(
  parameter int WIDTH = LINE_W,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             in_bit,
  output logic [WIDTH-1:0] line,
  output logic             last_bit
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] bitcnt;

  assign last_bit = (bitcnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitcnt <= '0;
      line   <= '0;
    end else if (clear) begin
      // Positions not yet rewritten keep their old contents.
      bitcnt <= '0;
    end else if (shift_en) begin
      line[bitcnt] <= in_bit;
      bitcnt       <= last_bit ? '0 : bitcnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/line_loader.sv
// Packs a handshaked serial stream into 25-bit plane lines and paces them
// against the permutation controller, NUM_LINES lines per job.
`default_nettype none

module line_loader
  import line_loader_pkg::*;
#(
  parameter int LINE_W    = line_loader_pkg::LINE_W,
  parameter int NUM_LINES = 64,
  parameter int IDX_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  output logic [LINE_W-1:0] line,
  output logic              initLine,
  input  logic              perm_done,
  output logic [IDX_W-1:0]  line_idx,
  output logic              busy,
  output logic              job_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

  state_t state;
  logic   shift_en;
  logic   clear;
  logic   last_bit;

  // in_ready is a registered copy of (state == SHIFT), so the handshake
  // qualifier depends only on state and never on in_valid.
  assign shift_en = (state == ST_SHIFT) && in_valid && in_ready;
  assign clear    = (state == ST_IDLE) && start;

  line_loader_bit_collector #(
    .WIDTH (LINE_W)
  ) u_collector (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .clear    (clear),
    .in_bit   (in_bit),
    .line     (line),
    .last_bit (last_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      line_idx <= '0;
      in_ready <= 1'b0;
      initLine <= 1'b0;
      busy     <= 1'b0;
      job_done <= 1'b0;
    end else begin
      initLine <= 1'b0;
      job_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_SHIFT;
            line_idx <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (shift_en && last_bit) begin
            state    <= ST_LOAD;
            in_ready <= 1'b0;
            initLine <= 1'b1;
          end
        end
        ST_LOAD: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (perm_done) begin
            if (line_idx == LAST_IDX) begin
              state    <= ST_FINISH;
              job_done <= 1'b1;
            end else begin
              state    <= ST_SHIFT;
              line_idx <= line_idx + 1'b1;
              in_ready <= 1'b1;
            end
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
